// File: rtl/rob_pkg.sv
// Shared geometry and entry layout for the superscalar reorder buffer.
// Field widths track the default ROB/PRF/REGS/XLEN configuration.
package rob_pkg;

   localparam int ROB_DEPTH = 32;
   localparam int PRF_SIZE  = 64;
   localparam int ARCH_REGS = 32;
   localparam int XLEN_W    = 32;

   localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
   localparam int PRN_W     = $clog2(PRF_SIZE);
   localparam int ARN_W     = $clog2(ARCH_REGS);

   // target holds the predicted target until completion, then the resolved next PC
   typedef struct packed {
      logic              valid;
      logic              done;
      logic              mispredict;
      logic              is_branch;
      logic              reg_write;
      logic              prediction;
      logic [PRN_W-1:0]  prn;
      logic [ARN_W-1:0]  arn;
      logic [XLEN_W-1:0] pc;
      logic [XLEN_W-1:0] target;
   } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Picks the in-order commit lanes from the head window and stops after the
// first mispredicted branch, which supplies the fetch redirect.
module rob_retire_sel #(
   parameter int WAYS = 3,
   parameter int XLEN = 32
) (
   input  logic [WAYS-1:0]           ent_ready,
   input  logic [WAYS-1:0]           ent_misp,
   input  logic [WAYS-1:0][XLEN-1:0] ent_target,
   output logic [WAYS-1:0]           commit_mask,
   output logic [WAYS-1:0]           squash_lane,
   output logic [XLEN-1:0]           redirect_pc
);

   logic open_c;

   always_comb begin
      commit_mask = '0;
      squash_lane = '0;
      redirect_pc = '0;
      open_c      = 1'b1;
      for (int k = 0; k < WAYS; k++) begin
         if (open_c && ent_ready[k]) begin
            commit_mask[k] = 1'b1;
            if (ent_misp[k]) begin
               squash_lane[k] = 1'b1;
               redirect_pc    = ent_target[k];
               open_c         = 1'b0;
            end
         end else begin
            open_c = 1'b0;
         end
      end
   end

endmodule

// File: rtl/rob_superscalar.sv
// N-way reorder buffer: multi-lane dispatch, CDB completion, in-order commit,
// and full flush with PC redirect when a mispredicted branch retires.
module rob_superscalar
   import rob_pkg::*;
#(
   parameter int WAYS = 3,
   parameter int ROB  = ROB_DEPTH,
   parameter int PRF  = PRF_SIZE,
   parameter int REGS = ARCH_REGS,
   parameter int XLEN = XLEN_W
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [WAYS-1:0]                   valid,
   input  logic [WAYS-1:0][$clog2(PRF)-1:0]  dest_PRN,
   input  logic [WAYS-1:0][$clog2(REGS)-1:0] dest_ARN,
   input  logic [WAYS-1:0]                   reg_write,
   input  logic [WAYS-1:0]                   is_branch,
   input  logic [WAYS-1:0][XLEN-1:0]         PC,
   input  logic [WAYS-1:0][XLEN-1:0]         inst_target,
   input  logic [WAYS-1:0]                   prediction,
   input  logic [WAYS-1:0]                   CDB_valid,
   input  logic [WAYS-1:0][$clog2(ROB)-1:0]  CDB_ROB_idx,
   input  logic [WAYS-1:0]                   CDB_direction,
   input  logic [WAYS-1:0][XLEN-1:0]         CDB_target,
   output logic [$clog2(ROB)-1:0]            tail_ptr,
   output logic [$clog2(ROB):0]              num_free,
   output logic [WAYS-1:0]                   valid_out,
   output logic [WAYS-1:0][$clog2(PRF)-1:0]  dest_PRN_out,
   output logic [WAYS-1:0][$clog2(REGS)-1:0] dest_ARN_out,
   output logic [WAYS-1:0]                   reg_write_out,
   output logic                              squash,
   output logic [XLEN-1:0]                   redirect_PC
);

   localparam int IW = $clog2(ROB);

   rob_entry_t [ROB-1:0] rob_q, rob_d;
   logic [IW-1:0]        head_q, head_d, tail_q, tail_d;
   logic [IW:0]          count_q, count_d;

   logic [IW:0]                free_w, n_disp, n_com;
   logic [WAYS-1:0]            disp_ok, ent_ready, ent_misp, commit_mask, squash_lane;
   logic [WAYS-1:0][XLEN-1:0]  ent_target;
   logic [XLEN-1:0]            sel_redirect;

   assign free_w = (IW+1)'(ROB) - count_q;

   // Head window: entries head..head+WAYS-1, wrapping mod ROB
   always_comb begin
      ent_ready     = '0;
      ent_misp      = '0;
      ent_target    = '0;
      dest_PRN_out  = '0;
      dest_ARN_out  = '0;
      reg_write_out = '0;
      for (int k = 0; k < WAYS; k++) begin
         ent_ready[k]  = rob_q[head_q + IW'(k)].valid & rob_q[head_q + IW'(k)].done;
         ent_misp[k]   = rob_q[head_q + IW'(k)].mispredict;
         ent_target[k] = rob_q[head_q + IW'(k)].target;
         if (commit_mask[k]) begin
            dest_PRN_out[k]  = rob_q[head_q + IW'(k)].prn;
            dest_ARN_out[k]  = rob_q[head_q + IW'(k)].arn;
            reg_write_out[k] = rob_q[head_q + IW'(k)].reg_write;
         end
      end
   end

   rob_retire_sel #(
      .WAYS (WAYS),
      .XLEN (XLEN)
   ) u_retire_sel (
      .ent_ready   (ent_ready),
      .ent_misp    (ent_misp),
      .ent_target  (ent_target),
      .commit_mask (commit_mask),
      .squash_lane (squash_lane),
      .redirect_pc (sel_redirect)
   );

   assign valid_out   = commit_mask;
   assign squash      = |squash_lane;
   assign redirect_PC = sel_redirect;
   assign tail_ptr    = tail_q;
   assign num_free    = free_w;

   always_comb begin
      rob_d   = rob_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      n_disp  = '0;
      n_com   = '0;
      disp_ok = '0;
      for (int i = 0; i < WAYS; i++) begin
         // lanes beyond the pre-commit free count are dropped
         disp_ok[i] = valid[i] && ((IW+1)'(i) < free_w);
         if (disp_ok[i]) n_disp = n_disp + (IW+1)'(1);
         if (commit_mask[i]) n_com = n_com + (IW+1)'(1);
      end
      if (squash) begin
         rob_d   = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // Later lanes overwrite earlier ones on duplicate indices
         for (int c = 0; c < WAYS; c++) begin
            if (CDB_valid[c] && rob_q[CDB_ROB_idx[c]].valid) begin
               rob_d[CDB_ROB_idx[c]].done = 1'b1;
               rob_d[CDB_ROB_idx[c]].mispredict = rob_q[CDB_ROB_idx[c]].is_branch &
                  ((CDB_direction[c] != rob_q[CDB_ROB_idx[c]].prediction) |
                   (CDB_direction[c] & (CDB_target[c] != rob_q[CDB_ROB_idx[c]].target)));
               rob_d[CDB_ROB_idx[c]].target = CDB_direction[c] ? CDB_target[c]
                                            : rob_q[CDB_ROB_idx[c]].pc + XLEN'(4);
            end
         end
         for (int k = 0; k < WAYS; k++) begin
            if (commit_mask[k]) rob_d[head_q + IW'(k)] = '0;
         end
         for (int i = 0; i < WAYS; i++) begin
            if (disp_ok[i]) begin
               rob_d[tail_q + IW'(i)] = '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                                          is_branch: is_branch[i], reg_write: reg_write[i],
                                          prediction: prediction[i], prn: dest_PRN[i],
                                          arn: dest_ARN[i], pc: PC[i], target: inst_target[i]};
            end
         end
         head_d  = head_q + n_com[IW-1:0];
         tail_d  = tail_q + n_disp[IW-1:0];
         count_d = count_q + n_disp - n_com;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rob_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         rob_q   <= rob_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_rob_superscalar.sv
// Randomized and directed bench for rob_superscalar against a queue-based
// model of the in-flight window.
module tb_rob_superscalar;

   localparam int WAYS = 3, ROB = 32, PW = 6, AW = 5, IW = 5, XLEN = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [WAYS-1:0]           valid, reg_write, is_branch, prediction;
   logic [WAYS-1:0][PW-1:0]   dest_PRN;
   logic [WAYS-1:0][AW-1:0]   dest_ARN;
   logic [WAYS-1:0][XLEN-1:0] PC, inst_target, CDB_target;
   logic [WAYS-1:0]           CDB_valid, CDB_direction;
   logic [WAYS-1:0][IW-1:0]   CDB_ROB_idx;
   logic [IW-1:0]             tail_ptr;
   logic [IW:0]               num_free;
   logic [WAYS-1:0]           valid_out, reg_write_out;
   logic [WAYS-1:0][PW-1:0]   dest_PRN_out;
   logic [WAYS-1:0][AW-1:0]   dest_ARN_out;
   logic                      squash;
   logic [XLEN-1:0]           redirect_PC;

   always #5 clock = ~clock;

   rob_superscalar #(.WAYS(WAYS), .ROB(ROB), .PRF(64), .REGS(32), .XLEN(XLEN)) dut (
      .clock(clock), .reset(reset), .valid(valid), .dest_PRN(dest_PRN), .dest_ARN(dest_ARN),
      .reg_write(reg_write), .is_branch(is_branch), .PC(PC), .inst_target(inst_target),
      .prediction(prediction), .CDB_valid(CDB_valid), .CDB_ROB_idx(CDB_ROB_idx),
      .CDB_direction(CDB_direction), .CDB_target(CDB_target), .tail_ptr(tail_ptr),
      .num_free(num_free), .valid_out(valid_out), .dest_PRN_out(dest_PRN_out),
      .dest_ARN_out(dest_ARN_out), .reg_write_out(reg_write_out), .squash(squash),
      .redirect_PC(redirect_PC)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Model: in-flight instructions oldest first, plus the allocation pointer
   typedef struct {
      int          idx, prn, arn;
      bit          rw, br, pred, done, misp, dir;
      logic [31:0] pc, itgt, rtgt;
   } ment_t;
   ment_t mq[$];
   int    m_tail = 0;

   function automatic int m_commit(output bit sq, output logic [31:0] red);
      int n = 0;
      sq = 1'b0;
      red = '0;
      for (int k = 0; k < WAYS; k++) begin
         if (k >= mq.size()) break;
         if (!mq[k].done) break;
         n++;
         if (mq[k].misp) begin
            sq = 1'b1;
            red = mq[k].dir ? mq[k].rtgt : mq[k].pc + 32'd4;
            break;
         end
      end
      return n;
   endfunction

   task automatic model_edge();
      int n, free0, acc;
      bit sq;
      logic [31:0] red;
      ment_t e;
      free0 = ROB - mq.size();
      n = m_commit(sq, red);
      if (sq) begin
         mq.delete();
         m_tail = 0;
         return;
      end
      for (int c = 0; c < WAYS; c++) begin
         if (CDB_valid[c]) begin
            for (int j = 0; j < mq.size(); j++) begin
               if (mq[j].idx == int'(CDB_ROB_idx[c])) begin
                  mq[j].done = 1'b1;
                  mq[j].dir  = CDB_direction[c];
                  mq[j].rtgt = CDB_target[c];
                  mq[j].misp = mq[j].br && ((mq[j].dir != mq[j].pred) ||
                               (mq[j].dir && (mq[j].rtgt != mq[j].itgt)));
               end
            end
         end
      end
      repeat (n) void'(mq.pop_front());
      acc = 0;
      for (int i = 0; i < WAYS; i++) if (valid[i]) acc++;
      if (acc > free0) acc = free0;
      for (int i = 0; i < acc; i++) begin
         e.idx = (m_tail + i) % ROB;
         e.prn = int'(dest_PRN[i]);  e.arn = int'(dest_ARN[i]);
         e.rw = reg_write[i];        e.br = is_branch[i];   e.pred = prediction[i];
         e.done = 1'b0;              e.misp = 1'b0;         e.dir = 1'b0;
         e.pc = PC[i];               e.itgt = inst_target[i]; e.rtgt = '0;
         mq.push_back(e);
      end
      m_tail = (m_tail + acc) % ROB;
   endtask

   task automatic check_model();
      int n;
      bit sq;
      logic [31:0] red;
      logic [WAYS-1:0] ev, erw;
      logic [WAYS*PW-1:0] eprn;
      logic [WAYS*AW-1:0] earn;
      n = m_commit(sq, red);
      ev = '0; erw = '0; eprn = '0; earn = '0;
      for (int k = 0; k < n; k++) begin
         ev[k] = 1'b1;
         erw[k] = mq[k].rw;
         eprn[k*PW +: PW] = PW'(mq[k].prn);
         earn[k*AW +: AW] = AW'(mq[k].arn);
      end
      chk("tail_ptr", tail_ptr, m_tail);
      chk("num_free", num_free, ROB - mq.size());
      chk("valid_out", valid_out, ev);
      chk("dest_PRN_out", dest_PRN_out, eprn);
      chk("dest_ARN_out", dest_ARN_out, earn);
      chk("reg_write_out", reg_write_out, erw);
      chk("squash", squash, sq);
      chk("redirect_PC", redirect_PC, red);
   endtask

   task automatic idle();
      valid = '0; dest_PRN = '0; dest_ARN = '0; reg_write = '0; is_branch = '0;
      PC = '0; inst_target = '0; prediction = '0;
      CDB_valid = '0; CDB_ROB_idx = '0; CDB_direction = '0; CDB_target = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      model_edge();
      idle();
      check_model();
   endtask

   task automatic disp(input int l, input int prn, input int arn, input bit rw, input bit br,
                       input logic [31:0] pc, input logic [31:0] tgt, input bit pred);
      valid[l] = 1'b1; dest_PRN[l] = PW'(prn); dest_ARN[l] = AW'(arn); reg_write[l] = rw;
      is_branch[l] = br; PC[l] = pc; inst_target[l] = tgt; prediction[l] = pred;
   endtask

   task automatic cdb(input int l, input int idx, input bit dir, input logic [31:0] tgt);
      CDB_valid[l] = 1'b1; CDB_ROB_idx[l] = IW'(idx); CDB_direction[l] = dir; CDB_target[l] = tgt;
   endtask

   // Reset is asserted mid-cycle to show its effect before any clock edge
   task automatic do_reset(input string tag);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk({tag, "_rst_free"}, num_free, 32);
      chk({tag, "_rst_tail"}, tail_ptr, 0);
      chk({tag, "_rst_vo"}, valid_out, 0);
      chk({tag, "_rst_sq"}, squash, 0);
      chk({tag, "_rst_red"}, redirect_PC, 0);
      #1;
      reset = 1'b0;
      mq.delete();
      m_tail = 0;
   endtask

   initial begin
      idle();
      do_reset("t1");

      // In-order commit waits for the oldest entry
      for (int i = 0; i < 3; i++) disp(i, 33 + i, 1 + i, 1, 0, 32'h40 + 4*i, 0, 0);
      tick();
      cdb(0, 1, 0, 0); cdb(1, 2, 0, 0);
      tick();
      chk("t2_vo_wait", valid_out, 3'b000);
      cdb(0, 0, 0, 0);
      tick();
      chk("t2_vo", valid_out, 3'b111);
      chk("t2_prn", dest_PRN_out, {6'd35, 6'd34, 6'd33});
      tick();
      chk("t2_free", num_free, 32);

      // Fill to full, drop the overflow lane, then wrap the tail
      do_reset("t3");
      for (int c = 0; c < 11; c++) begin
         chk("t3_free_step", num_free, 32 - 3*c);
         for (int i = 0; i < 3; i++) disp(i, $urandom_range(0, 63), $urandom_range(0, 31), 1, 0, 0, 0, 0);
         tick();
      end
      chk("t3_full", num_free, 0);
      chk("t3_tail_full", tail_ptr, 0);
      cdb(0, 0, 0, 0); cdb(1, 1, 0, 0); cdb(2, 2, 0, 0);
      tick();
      chk("t3_vo", valid_out, 3'b111);
      tick();
      chk("t3_free3", num_free, 3);
      for (int i = 0; i < 3; i++) disp(i, 7, 7, 1, 0, 0, 0, 0);
      tick();
      chk("t3_tail_wrap", tail_ptr, 3);
      chk("t3_free0", num_free, 0);

      // Predicted not-taken, resolved taken
      do_reset("t4");
      disp(0, 40, 5, 0, 1, 32'h100, 32'h104, 0);
      disp(1, 41, 6, 1, 0, 32'h104, 0, 0);
      disp(2, 42, 7, 1, 0, 32'h108, 0, 0);
      tick();
      cdb(0, 0, 1, 32'h200); cdb(1, 1, 0, 0); cdb(2, 2, 0, 0);
      tick();
      chk("t4_vo", valid_out, 3'b001);
      chk("t4_sq", squash, 1);
      chk("t4_red", redirect_PC, 32'h200);
      tick();
      chk("t4_free", num_free, 32);
      chk("t4_tail", tail_ptr, 0);
      chk("t4_vo_after", valid_out, 3'b000);

      // Correctly predicted taken, then predicted taken but resolved not-taken
      disp(0, 40, 5, 0, 1, 32'h100, 32'h200, 1);
      disp(1, 41, 6, 1, 0, 32'h104, 0, 0);
      disp(2, 42, 7, 1, 0, 32'h108, 0, 0);
      tick();
      cdb(0, 0, 1, 32'h200); cdb(1, 1, 0, 0); cdb(2, 2, 0, 0);
      tick();
      chk("t5_sq_hit", squash, 0);
      chk("t5_vo_hit", valid_out, 3'b111);
      tick();
      disp(0, 43, 8, 0, 1, 32'h100, 32'h200, 1);
      disp(1, 44, 9, 1, 0, 32'h104, 0, 0);
      disp(2, 45, 10, 1, 0, 32'h108, 0, 0);
      tick();
      cdb(0, 3, 0, 32'h0); cdb(1, 4, 0, 0); cdb(2, 5, 0, 0);
      tick();
      chk("t5_sq_nt", squash, 1);
      chk("t5_red_nt", redirect_PC, 32'h104);
      chk("t5_vo_nt", valid_out, 3'b001);
      tick();

      // Asynchronous reset with 20 entries held
      do_reset("t6a");
      for (int c = 0; c < 7; c++) begin
         for (int i = 0; i < ((c == 6) ? 2 : 3); i++) disp(i, 50, 3, 1, 0, 0, 0, 0);
         tick();
      end
      chk("t6_free_occ", num_free, 12);
      cdb(0, 0, 0, 0); cdb(1, 1, 0, 0); cdb(2, 2, 0, 0);
      tick();
      chk("t6_vo_pre", valid_out, 3'b111);
      do_reset("t6");

      // Random traffic against the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int nd;
         nd = $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0) nd = 3;
         for (int i = 0; i < nd; i++)
            disp(i, $urandom_range(0, 63), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), $urandom & 32'hfffc,
                 $urandom_range(0, 1) ? 32'h200 : 32'h300, 1'($urandom_range(0, 1)));
         for (int c = 0; c < WAYS; c++) begin
            if ($urandom_range(0, 1) == 1) begin
               if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
                  int j;
                  j = $urandom_range(0, mq.size() - 1);
                  if (!mq[j].done)
                     cdb(c, mq[j].idx, 1'($urandom_range(0, 1)),
                         $urandom_range(0, 1) ? 32'h200 : 32'h300);
               end else if (mq.size() < ROB) begin
                  cdb(c, (m_tail + $urandom_range(0, ROB - 1 - mq.size())) % ROB, 1'b1, 32'h200);
               end
            end
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
